// File: rtl/frame_controller.sv
// Frame sequencer for the lane-detection accelerator: pixel load, compute, result-ready.
// Also gates input FIFO writes, stretches soft reset requests and tracks status flags.
module frame_controller #(
  parameter int unsigned NUM_PIXELS        = 131072,
  parameter int unsigned SOFT_RESET_CYCLES = 15,
  parameter int unsigned TIMEOUT_CYCLES    = 4194304,
  parameter int unsigned FRAME_CNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       soft_reset_req,
  input  logic                       pixel_wr_en,
  output logic                       pixel_accept,
  input  logic                       model_done,
  input  logic                       irq_en,
  input  logic                       irq_clear,
  output logic                       internal_rst_n,
  output logic                       busy,
  output logic                       done,
  output logic                       irq,
  output logic                       err_overrun,
  output logic                       err_timeout,
  output logic [1:0]                 state,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

  localparam int unsigned PixW = $clog2(NUM_PIXELS + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RstW = $clog2(SOFT_RESET_CYCLES + 1);

  localparam logic [PixW-1:0] PixLast = PixW'(NUM_PIXELS - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);
  localparam logic [RstW-1:0] RstLast = RstW'(SOFT_RESET_CYCLES);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLoad    = 2'd1,
    StCompute = 2'd2,
    StDone    = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [PixW-1:0]            pix_cnt_q, pix_cnt_d;
  logic [ToW-1:0]             to_cnt_q, to_cnt_d;
  logic [RstW-1:0]            rst_cnt_q, rst_cnt_d;
  logic                       irn_q, irn_d;
  logic                       irq_q, irq_d;
  logic                       err_overrun_q, err_overrun_d;
  logic                       err_timeout_q, err_timeout_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       frame_end;
  logic                       hold;

  // Soft reset stretcher: counts 1..SOFT_RESET_CYCLES then returns to idle (0).
  always_comb begin
    rst_cnt_d = rst_cnt_q;
    if (rst_cnt_q != '0) begin
      rst_cnt_d = (rst_cnt_q == RstLast) ? '0 : rst_cnt_q + RstW'(1);
    end else if (soft_reset_req) begin
      rst_cnt_d = RstW'(1);
    end
  end

  assign irn_d = (rst_cnt_d == '0);
  // Datapath is held whenever the internal reset is (or is about to be) asserted.
  assign hold  = !irn_q || (rst_cnt_d != '0);

  assign pixel_accept = pixel_wr_en & irn_q & (state_q != StCompute);

  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    to_cnt_d      = to_cnt_q;
    irq_d         = irq_q;
    err_overrun_d = err_overrun_q;
    err_timeout_d = err_timeout_q;
    frame_count_d = frame_count_q;
    frame_end     = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (pixel_wr_en) begin
          state_d   = StLoad;
          pix_cnt_d = PixW'(1);
        end
      end
      StLoad: begin
        if (pixel_wr_en) begin
          if (pix_cnt_q == PixLast) begin
            state_d   = StCompute;
            pix_cnt_d = '0;
            to_cnt_d  = '0;
          end else begin
            pix_cnt_d = pix_cnt_q + PixW'(1);
          end
        end
      end
      StCompute: begin
        to_cnt_d = to_cnt_q + ToW'(1);
        if (pixel_wr_en) begin
          err_overrun_d = 1'b1;
        end
        // model_done takes priority over a coincident timeout.
        if (model_done) begin
          state_d       = StDone;
          frame_count_d = frame_count_q + FRAME_CNT_WIDTH'(1);
          frame_end     = 1'b1;
        end else if (to_cnt_q == ToLast) begin
          state_d       = StDone;
          err_timeout_d = 1'b1;
          frame_end     = 1'b1;
        end
      end
      default: ;
    endcase

    if (frame_end && irq_en) begin
      irq_d = 1'b1;
    end else if (irq_clear) begin
      irq_d = 1'b0;
    end

    if (hold) begin
      state_d       = StIdle;
      pix_cnt_d     = '0;
      to_cnt_d      = '0;
      irq_d         = 1'b0;
      err_overrun_d = 1'b0;
      err_timeout_d = 1'b0;
      frame_count_d = '0;
    end
  end

  assign busy_d = (state_d == StLoad) || (state_d == StCompute);
  assign done_d = (state_d == StDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pix_cnt_q     <= '0;
      to_cnt_q      <= '0;
      rst_cnt_q     <= '0;
      irn_q         <= 1'b0;
      irq_q         <= 1'b0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
      frame_count_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      to_cnt_q      <= to_cnt_d;
      rst_cnt_q     <= rst_cnt_d;
      irn_q         <= irn_d;
      irq_q         <= irq_d;
      err_overrun_q <= err_overrun_d;
      err_timeout_q <= err_timeout_d;
      frame_count_q <= frame_count_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign internal_rst_n = irn_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign irq            = irq_q;
  assign err_overrun    = err_overrun_q;
  assign err_timeout    = err_timeout_q;
  assign state          = state_q;
  assign frame_count    = frame_count_q;

endmodule

// File: tb/tb_frame_controller.sv
// Bench for frame_controller: vector table, directed corner cases and random traffic
// checked every cycle against a behavioural model of the frame sequencer.
module tb_frame_controller;

  localparam int NP  = 16;
  localparam int SRC = 15;
  localparam int TO  = 100;
  localparam int FCW = 16;

  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_COMPUTE = 2, PH_DONE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic soft_reset_req = 1'b0, pixel_wr_en = 1'b0, model_done = 1'b0;
  logic irq_en = 1'b0, irq_clear = 1'b0;
  logic pixel_accept, internal_rst_n, busy, done, irq, err_overrun, err_timeout;
  logic [1:0] state;
  logic [FCW-1:0] frame_count;

  frame_controller #(
    .NUM_PIXELS       (NP),
    .SOFT_RESET_CYCLES(SRC),
    .TIMEOUT_CYCLES   (TO),
    .FRAME_CNT_WIDTH  (FCW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .soft_reset_req(soft_reset_req),
    .pixel_wr_en   (pixel_wr_en),
    .pixel_accept  (pixel_accept),
    .model_done    (model_done),
    .irq_en        (irq_en),
    .irq_clear     (irq_clear),
    .internal_rst_n(internal_rst_n),
    .busy          (busy),
    .done          (done),
    .irq           (irq),
    .err_overrun   (err_overrun),
    .err_timeout   (err_timeout),
    .state         (state),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic acc_seen;

  // Behavioural model: frame phase, pixels received, cycles spent computing,
  // remaining soft-reset cycles.
  int m_phase, m_pixels, m_age, m_left, m_frame;
  bit m_irn, m_irq, m_ovr, m_to;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_phase = PH_IDLE; m_pixels = 0; m_age = 0; m_frame = 0;
    m_irq = 0; m_ovr = 0; m_to = 0;
  endfunction

  function automatic void model_step(bit pw, bit md, bit sr, bit ie, bit ic);
    int  left_new;
    bit  finished;
    if (m_left > 0) left_new = m_left - 1;
    else if (sr)    left_new = SRC;
    else            left_new = 0;
    if (!m_irn || left_new != 0) begin
      model_clear();
      m_left = left_new;
      m_irn  = (left_new == 0);
      return;
    end
    finished = 0;
    case (m_phase)
      PH_IDLE, PH_DONE: if (pw) begin m_phase = PH_LOAD; m_pixels = 1; end
      PH_LOAD: if (pw) begin
        m_pixels++;
        if (m_pixels == NP) begin m_phase = PH_COMPUTE; m_pixels = 0; m_age = 0; end
      end
      default: begin
        m_age++;
        if (pw) m_ovr = 1;
        if (md) begin
          m_phase = PH_DONE; m_frame = (m_frame + 1) % (1 << FCW); finished = 1;
        end else if (m_age == TO) begin
          m_phase = PH_DONE; m_to = 1; finished = 1;
        end
      end
    endcase
    if (finished && ie) m_irq = 1;
    else if (ic)        m_irq = 0;
  endfunction

  task automatic check_model();
    check("state", state, m_phase);
    check("busy", busy, (m_phase == PH_LOAD || m_phase == PH_COMPUTE));
    check("done", done, m_phase == PH_DONE);
    check("irq", irq, m_irq);
    check("err_overrun", err_overrun, m_ovr);
    check("err_timeout", err_timeout, m_to);
    check("frame_count", frame_count, m_frame);
    check("internal_rst_n", internal_rst_n, m_irn);
  endtask

  // One clock: drive at negedge, check combinational accept, model the edge, check after it.
  task automatic cycle(input logic pw, input logic md, input logic sr, input logic ie,
                       input logic ic);
    @(negedge clk);
    pixel_wr_en = pw; model_done = md; soft_reset_req = sr; irq_en = ie; irq_clear = ic;
    #1;
    acc_seen = pixel_accept;
    check("pixel_accept", pixel_accept, pw && m_irn && (m_phase != PH_COMPUTE));
    @(posedge clk);
    model_step(pw, md, sr, ie, ic);
    #1;
    check_model();
  endtask

  task automatic hw_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    pixel_wr_en = 0; model_done = 0; soft_reset_req = 0; irq_en = 0; irq_clear = 0;
    #1;
    check("rst_state", state, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_irq", irq, 0);
    check("rst_err_overrun", err_overrun, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_internal_rst_n", internal_rst_n, 0);
    model_clear(); m_left = 0; m_irn = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic soft_reset();
    cycle(0, 0, 1, 0, 0);
    repeat (SRC) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic load_frame(input logic ie);
    repeat (NP) cycle(1, 0, 0, ie, 0);
  endtask

  typedef struct {
    logic       pw, md, ic;
    logic [1:0] st;
    logic       acc;
    int         fc;
    logic       irq, ovr;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic pw, logic md, logic ic, logic [1:0] st, logic acc, int fc,
                              logic iq, logic ovr);
    vec_t v;
    v.pw = pw; v.md = md; v.ic = ic; v.st = st; v.acc = acc; v.fc = fc; v.irq = iq; v.ovr = ovr;
    tbl.push_back(v);
  endfunction

  initial begin
    int n;
    int low;

    // Frame 1 with gaps, overrun during compute, irq clear, ignored stale done,
    // back-to-back frame 2, then done and irq_clear together.
    for (int i = 0; i < NP; i++) begin
      add(1, 0, 0, (i == NP - 1) ? 2'd2 : 2'd1, 1, 0, 0, 0);
      if (i < NP - 1) add(0, 0, 0, 2'd1, 0, 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) add(1, 0, 0, 2'd2, 0, 0, 0, 1);
    add(0, 1, 0, 2'd3, 0, 1, 1, 1);
    add(0, 0, 1, 2'd3, 0, 1, 0, 1);
    add(0, 1, 0, 2'd3, 0, 1, 0, 1);
    for (int i = 0; i < NP; i++) add(1, 0, 0, (i == NP - 1) ? 2'd2 : 2'd1, 1, 1, 0, 1);
    add(0, 1, 1, 2'd3, 0, 2, 1, 1);

    hw_reset();
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].pw, tbl[i].md, 1'b0, 1'b1, tbl[i].ic);
      check($sformatf("tbl%0d_accept", i), acc_seen, tbl[i].acc);
      check($sformatf("tbl%0d_state", i), state, tbl[i].st);
      check($sformatf("tbl%0d_frame", i), frame_count, tbl[i].fc);
      check($sformatf("tbl%0d_irq", i), irq, tbl[i].irq);
      check($sformatf("tbl%0d_overrun", i), err_overrun, tbl[i].ovr);
    end

    // Timeout with no model_done: DONE after exactly TO compute cycles.
    soft_reset();
    load_frame(1);
    n = 0;
    while (state == 2'd2 && n < 3 * TO) begin
      n++;
      cycle(0, 0, 0, 1, 0);
    end
    check("timeout_cycles", n, TO);
    check("timeout_err", err_timeout, 1);
    check("timeout_frame", frame_count, 0);
    check("timeout_irq", irq, 1);

    // model_done on the last possible cycle wins over the timeout; irq_en=0 keeps irq low.
    soft_reset();
    load_frame(0);
    n = 0;
    while (state == 2'd2 && n < 3 * TO) begin
      n++;
      cycle(0, (n == TO), 0, 0, 0);
    end
    check("late_done_cycles", n, TO);
    check("late_done_err", err_timeout, 0);
    check("late_done_frame", frame_count, 1);
    check("late_done_irq", irq, 0);

    // Soft reset mid-load at pixel count 7, with writes hammered through the window.
    soft_reset();
    repeat (7) cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    low = 0;
    while (!internal_rst_n && low < 4 * SRC) begin
      low++;
      cycle(1, 0, 0, 0, 0);
      check("sr_accept_blocked", acc_seen, 0);
      check("sr_state_idle", state, 0);
    end
    check("sr_low_cycles", low, SRC);
    repeat (NP - 1) cycle(1, 0, 0, 0, 0);
    check("sr_count_cleared_load", state, 1);
    cycle(1, 0, 0, 0, 0);
    check("sr_count_cleared_compute", state, 2);

    // Async reset in the middle of a compute with irq, frame count and overrun all set.
    cycle(0, 1, 0, 1, 0);
    load_frame(1);
    cycle(1, 0, 0, 1, 0);
    check("pre_rst_state", state, 2);
    hw_reset();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 1,
            $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 10);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
